joojump_mem_copy_master: RTL and testbench
==========================================

# joojump_mem_copy_master

- Avalon-MM master that copies a block of 32-bit words from one word-aligned byte address to another.
- Typical use: moving data inside the JooJump on-chip RAM, or between that RAM and any other Avalon-MM slave.
- Sits beside the processor on the system interconnect. It is started by a one-cycle command pulse and reports completion with a one-cycle `done` pulse.
- Issues one read, then one write, per word; never more than one outstanding transaction.

## Interface
Parameters:
- `ADDR_W`, 12: byte-address width. 4 KiB = 1024 words × 4 B.
- `LEN_W`, 11: width of the word count. Allows 0..1024 words.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `start`  in  1: command pulse. Sampled only in IDLE.
- `src_addr`  in  ADDR_W: source byte address. Must be word aligned.
- `dst_addr`  in  ADDR_W: destination byte address. Must be word aligned.
- `len_words`  in  LEN_W: number of words to copy.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `done`  out  1: one-cycle completion pulse.
- `error`  out  1: valid with `done`. High means the command was rejected because it was misaligned.
- `avm_address`  out  ADDR_W: byte address.
- `avm_read`  out  1: read request.
- `avm_write`  out  1: write request.
- `avm_writedata`  out  32: write data.
- `avm_byteenable`  out  4: always 4'hF while `avm_write` is high, else 4'h0.
- `avm_waitrequest`  in  1: slave stall.
- `avm_readdata`  in  32: read data.
- `avm_readdatavalid`  in  1: read data strobe.

## Operation
States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN.

- **IDLE**
  - Nothing happens unless `start` is high.
  - On `start`, latch `src_addr`, `dst_addr` and `len_words`, and clear the word index `i`.
  - If either address has nonzero bits [1:0], go to FIN with `error`=1. No bus activity occurs.
  - Else if `len_words`==0, go to FIN with `error`=0. No bus activity occurs.
  - Else go to RD_REQ.
- **RD_REQ**
  - Drive `avm_read`=1 and `avm_address` = `src` + 4·`i` (modulo 2^ADDR_W).
  - Hold address and `avm_read` stable while `avm_waitrequest`=1.
  - Go to RD_WAIT on the first cycle with `avm_waitrequest`=0.
- **RD_WAIT**
  - All requests are low.
  - On `avm_readdatavalid`=1, capture `avm_readdata` into the data register and go to WR_REQ.
- **WR_REQ**
  - Drive `avm_write`=1, `avm_address` = `dst` + 4·`i` (modulo 2^ADDR_W), and `avm_writedata` = captured word.
  - Hold all three stable while `avm_waitrequest`=1.
  - When the write is accepted: if `i` == `len`−1, go to FIN; else increment `i` and go to RD_REQ.
- **FIN**
  - `done`=1 for exactly one cycle, with `busy`=0 in that cycle. Then go to IDLE.

Boundary rules:
- `start` in any state other than IDLE is ignored. There is no command queue.
- A `start` in the same cycle as `done` is ignored, because the FSM is in FIN, not IDLE.
- `avm_readdatavalid` outside RD_WAIT is ignored. No data is captured.
- Address wrap is legal: it wraps modulo 2^ADDR_W silently.
- `avm_read` and `avm_write` are never high together.
- Overlapping source and destination ranges are copied strictly in ascending order. The result follows from that ordering; no overlap handling is provided.
- Reset mid-transfer: at the next clock edge the FSM is in IDLE, and `busy`, `done`, `error`, `avm_read` and `avm_write` are all 0. The partial transfer is abandoned. A late `avm_readdatavalid` after reset is ignored.

## Timing
- Reset values:
  - All outputs are 0, including `avm_address`, `avm_writedata` and `avm_byteenable`.
  - State is IDLE and `i`=0.
- `start` sampled at edge k:
  - `busy`=1 and `avm_read`=1 in cycle k+1, for a valid non-zero command.
  - For a zero-length or misaligned command, `done` is high in cycle k+1 and `busy` stays 0.
- Zero waitrequest, slave with fixed read latency 1: each word takes 3 cycles (RD_REQ, RD_WAIT, WR_REQ).
  - An N-word copy has `busy` high for 3N cycles, followed by 1 `done` cycle.
- Each waitrequest cycle adds one cycle. Each extra read-latency cycle adds one cycle.
- Outputs are registered, or decoded only from state and registers. There is no combinational path from any input to any output.

## Structure
- Package `joojump_copy_pkg` holds:
  - the state enum `copy_state_t` (IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN);
  - the constant `WORD_BYTES`=4;
  - the constant `BE_ALL`=4'hF.
- A single module. No sub-module is warranted; the index counter and address adders are inline.

## Test plan
- **Basic copy.** Preload the slave model with 0x11111111..0x44444444 at 0x000..0x00C. `start`, src=0x000, dst=0x100, len=4, no waitrequest, latency 1.
  - Expect words at 0x100..0x10C to match.
  - Expect `busy` high for 12 cycles, then `done`=1 with `error`=0.
- **Stalls.** Same copy with random `avm_waitrequest` and read latency 1–3.
  - Expect address, data and request held stable during every stall.
  - Expect identical final memory.
- **Rejected and empty commands.**
  - src=0x002, len=4: `done`=1 and `error`=1 in cycle k+1; zero bus cycles.
  - len=0 with aligned addresses: `done`=1 and `error`=0; zero bus cycles.
- **Wrap.** src=0xFF8, dst=0x010, len=4.
  - Expect reads at 0xFF8, 0xFFC, 0x000, 0x004.
  - Expect writes at 0x010..0x01C.
- **Reset mid-operation.** Assert `reset` during the second WR_REQ of a len=8 copy.
  - Next cycle: all outputs 0.
  - A spurious `avm_readdatavalid` afterwards causes no write.
  - A fresh `start` then completes normally.
- **Ignored start.** Pulse `start` with new arguments while `busy`=1.
  - Expect the original transfer to complete unchanged, with exactly one `done`.

Source files
------------

// File: rtl/joojump_copy_pkg.sv
// Shared types and constants for the JooJump word-copy bus master.
package joojump_copy_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    FIN     = 3'd4
  } copy_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  BE_ALL     = 4'hF;

endpackage

// File: rtl/joojump_mem_copy_master.sv
// Avalon-MM master copying len_words 32-bit words from src_addr to dst_addr, one read then one
// write per word with a single outstanding transaction. All outputs decode from state/registers.
module joojump_mem_copy_master
  import joojump_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  copy_state_t       state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q, idx_q;
  logic [31:0]       data_q;
  logic              error_q;

  logic              misaligned;
  logic              last_word;
  logic [ADDR_W-1:0] offset;

  assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
  assign last_word  = (idx_q == len_q - LEN_W'(1));
  // Byte offset of the current word; wraps modulo 2^ADDR_W by truncation.
  assign offset     = ADDR_W'(idx_q) * ADDR_W'(WORD_BYTES);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (misaligned || (len_words == '0)) begin
            state_d = FIN;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (avm_readdatavalid) state_d = WR_REQ;
      end
      WR_REQ: begin
        if (!avm_waitrequest) state_d = last_word ? FIN : RD_REQ;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        src_q   <= src_addr;
        dst_q   <= dst_addr;
        len_q   <= len_words;
        idx_q   <= '0;
        error_q <= misaligned;
      end
      // Read data is only captured while a read is actually outstanding.
      if ((state_q == RD_WAIT) && avm_readdatavalid) begin
        data_q <= avm_readdata;
      end
      if ((state_q == WR_REQ) && !avm_waitrequest && !last_word) begin
        idx_q <= idx_q + LEN_W'(1);
      end
    end
  end

  always_comb begin
    busy           = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);
    done           = (state_q == FIN);
    error          = (state_q == FIN) && error_q;
    avm_read       = (state_q == RD_REQ);
    avm_write      = (state_q == WR_REQ);
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = 4'h0;
    if (state_q == RD_REQ) begin
      avm_address = src_q + offset;
    end else if (state_q == WR_REQ) begin
      avm_address    = dst_q + offset;
      avm_writedata  = data_q;
      avm_byteenable = BE_ALL;
    end
  end

endmodule

// File: tb/tb_joojump_mem_copy_master.sv
// Directed/randomized bench: a memory slave model with random stalls and latency, plus a
// word-level copy model predicting the memory image, bus address sequences and cycle counts.
module tb_joojump_mem_copy_master;

  localparam int unsigned WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] src_addr;
  logic [11:0] dst_addr;
  logic [10:0] len_words;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  int checks = 0;
  int errors = 0;

  // Written only by the slave process.
  logic [31:0] mem [WORDS];
  logic [11:0] rd_log [$];
  logic [11:0] wr_log [$];
  int          stall_cnt = 0;
  int          extra_lat = 0;

  // Written only by the main process.
  logic [31:0] exp_mem [WORDS];
  bit          stall_mode = 1'b0;
  bit          inject_rvalid = 1'b0;

  always #5 clk = ~clk;

  joojump_mem_copy_master #(
    .ADDR_W(12),
    .LEN_W (11)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .len_words        (len_words),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_busy"},  32'(busy), 32'd0);
    check({pfx, "_done"},  32'(done), 32'd0);
    check({pfx, "_error"}, 32'(error), 32'd0);
    check({pfx, "_read"},  32'(avm_read), 32'd0);
    check({pfx, "_write"}, 32'(avm_write), 32'd0);
    check({pfx, "_addr"},  32'(avm_address), 32'd0);
    check({pfx, "_wdata"}, avm_writedata, 32'd0);
    check({pfx, "_be"},    32'(avm_byteenable), 32'd0);
  endtask

  // Slave: decisions are made on the falling edge and take effect at the next rising edge.
  initial begin : slave
    bit          pend;
    int          pend_cnt;
    logic [11:0] pend_addr;
    bit          p_stall;
    logic        p_rd, p_wr;
    logic [11:0] p_addr;
    logic [31:0] p_wd;
    pend = 1'b0; pend_cnt = 0; pend_addr = '0;
    p_stall = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_wd = '0;
    for (int w = 0; w < int'(WORDS); w++) mem[w] = $urandom;
    mem[0] = 32'h11111111;
    mem[1] = 32'h22222222;
    mem[2] = 32'h33333333;
    mem[3] = 32'h44444444;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(negedge clk);
      check("rd_wr_exclusive", 32'(avm_read & avm_write), 32'd0);
      if (p_stall) begin
        check("stall_read_held",  32'(avm_read), 32'(p_rd));
        check("stall_write_held", 32'(avm_write), 32'(p_wr));
        check("stall_addr_held",  32'(avm_address), 32'(p_addr));
        if (p_wr) check("stall_wdata_held", avm_writedata, p_wd);
      end
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      if (inject_rvalid) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'hDEADBEEF;
      end else if (pend) begin
        if (pend_cnt <= 1) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = mem[pend_addr[11:2]];
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      avm_waitrequest = stall_mode && ($urandom_range(0, 2) == 0);
      if ((avm_read || avm_write) && avm_waitrequest) stall_cnt++;
      if (avm_read && !avm_waitrequest) begin
        rd_log.push_back(avm_address);
        pend = 1'b1;
        pend_addr = avm_address;
        pend_cnt = stall_mode ? int'($urandom_range(1, 3)) : 1;
        extra_lat += pend_cnt - 1;
      end
      if (avm_write && !avm_waitrequest) begin
        check("write_byteenable", 32'(avm_byteenable), 32'h0000000F);
        wr_log.push_back(avm_address);
        mem[avm_address[11:2]] = avm_writedata;
      end
      p_stall = (avm_read || avm_write) && avm_waitrequest;
      p_rd = avm_read;
      p_wr = avm_write;
      p_addr = avm_address;
      p_wd = avm_writedata;
    end
  end

  // One command, entered and left on a falling edge. glitch=1 also pulses start mid-transfer
  // and again in the done cycle; both must be ignored.
  task automatic run_copy(input logic [11:0] s, input logic [11:0] d, input logic [10:0] n,
                          input bit glitch);
    logic [11:0] exp_rd [$];
    logic [11:0] exp_wr [$];
    bit exp_err, got_done, done_err;
    int exp_n, busy_n, rd_base, wr_base, st_base, lat_base, bad, extra_done;
    exp_err = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    exp_n = exp_err ? 0 : int'(n);
    for (int w = 0; w < int'(WORDS); w++) exp_mem[w] = mem[w];
    for (int j = 0; j < exp_n; j++) begin
      logic [11:0] ra, wa;
      ra = s + 12'(4 * j);
      wa = d + 12'(4 * j);
      exp_rd.push_back(ra);
      exp_wr.push_back(wa);
      exp_mem[wa[11:2]] = exp_mem[ra[11:2]];
    end
    rd_base = rd_log.size();
    wr_base = wr_log.size();
    st_base = stall_cnt;
    lat_base = extra_lat;

    start = 1'b1; src_addr = s; dst_addr = d; len_words = n;
    @(negedge clk);
    start = 1'b0;
    if (exp_n == 0) begin
      check("k1_done",  32'(done), 32'd1);
      check("k1_error", 32'(error), 32'(exp_err));
      check("k1_busy",  32'(busy), 32'd0);
    end else begin
      check("k1_busy",  32'(busy), 32'd1);
      check("k1_read",  32'(avm_read), 32'd1);
      check("k1_addr",  32'(avm_address), 32'(s));
    end

    busy_n = 0; got_done = 1'b0; done_err = 1'b0;
    for (int c = 0; c < 20000 && !got_done; c++) begin
      if (glitch && c == 4) begin
        start = 1'b1; src_addr = 12'h800; dst_addr = 12'h900; len_words = 11'd2;
      end else if (glitch && c == 5) begin
        start = 1'b0;
      end
      if (done) begin
        got_done = 1'b1;
        done_err = error;
      end else begin
        if (busy) busy_n++;
        @(negedge clk);
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("done_error", 32'(done_err), 32'(exp_err));
    check("done_busy_low", 32'(busy), 32'd0);
    check("busy_cycles", busy_n, 3 * exp_n + (stall_cnt - st_base) + (extra_lat - lat_base));

    if (glitch) begin
      start = 1'b1; src_addr = 12'h800; dst_addr = 12'h810; len_words = 11'd3;
    end
    @(negedge clk);
    start = 1'b0;
    check("post_done_busy", 32'(busy), 32'd0);
    extra_done = 0;
    repeat (6) begin
      if (done) extra_done++;
      @(negedge clk);
    end
    check("single_done", extra_done, 0);

    check("rd_count", rd_log.size() - rd_base, exp_rd.size());
    check("wr_count", wr_log.size() - wr_base, exp_wr.size());
    bad = 0;
    for (int j = 0; j < exp_rd.size() && rd_base + j < rd_log.size(); j++)
      if (rd_log[rd_base + j] !== exp_rd[j]) bad++;
    for (int j = 0; j < exp_wr.size() && wr_base + j < wr_log.size(); j++)
      if (wr_log[wr_base + j] !== exp_wr[j]) bad++;
    check("addr_sequence", bad, 0);
    bad = 0;
    for (int w = 0; w < int'(WORDS); w++) if (mem[w] !== exp_mem[w]) bad++;
    check("mem_image", bad, 0);
  endtask

  initial begin : main
    int  rises;
    bit  prev_wr;
    int  wr_snap;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic copy: 12 busy cycles, then done with error=0.
    run_copy(12'h000, 12'h100, 11'd4, 1'b0);
    check("basic_w0", mem[64], 32'h11111111);
    check("basic_w1", mem[65], 32'h22222222);
    check("basic_w2", mem[66], 32'h33333333);
    check("basic_w3", mem[67], 32'h44444444);

    // Stalls and variable latency.
    stall_mode = 1'b1;
    run_copy(12'h000, 12'h100, 11'd4, 1'b0);
    run_copy(12'h300, 12'h308, 11'd6, 1'b0);
    repeat (3) begin
      run_copy(12'(4 * $urandom_range(0, 1023)), 12'(4 * $urandom_range(0, 1023)),
               11'($urandom_range(1, 12)), 1'b0);
    end
    stall_mode = 1'b0;

    // Rejected and empty commands.
    run_copy(12'h002, 12'h100, 11'd4, 1'b0);
    run_copy(12'h100, 12'h101, 11'd4, 1'b0);
    run_copy(12'h200, 12'h300, 11'd0, 1'b0);

    // Address wrap.
    run_copy(12'hFF8, 12'h010, 11'd4, 1'b0);

    // Reset during the second write of an 8-word copy.
    start = 1'b1; src_addr = 12'h000; dst_addr = 12'h600; len_words = 11'd8;
    @(negedge clk);
    start = 1'b0;
    rises = 0; prev_wr = 1'b0;
    for (int c = 0; c < 200 && rises < 2; c++) begin
      if (avm_write && !prev_wr) rises++;
      prev_wr = avm_write;
      if (rises < 2) @(negedge clk);
    end
    check("reset_mid_reached", rises, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_quiet("reset_mid");
    wr_snap = wr_log.size();
    @(posedge clk);
    inject_rvalid = 1'b1;
    @(posedge clk);
    inject_rvalid = 1'b0;
    repeat (8) @(negedge clk);
    check("late_rvalid_no_write", wr_log.size(), wr_snap);
    check("late_rvalid_idle", 32'(busy), 32'd0);
    run_copy(12'h000, 12'h600, 11'd8, 1'b0);

    // Starts while busy and in the done cycle are ignored.
    run_copy(12'h040, 12'h400, 11'd4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
